// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue and committed to HI/LO when the busy window ends.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_MDUA,
  input  logic [31:0] E_MDUB,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } mdu_op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] hi, hi_n, lo, lo_n;
  logic [31:0] res_hi, res_hi_n, res_lo, res_lo_n;
  logic        res_wr, res_wr_n;
  mdu_op_t     op;

  assign op = mdu_op_t'(E_MDUOp);

  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{E_MDUA[31]}}, E_MDUA}) * $signed({{32{E_MDUB[31]}}, E_MDUB});
  assign prod_u = {32'd0, E_MDUA} * {32'd0, E_MDUB};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  logic        div_signed, q_neg, r_neg;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, div_q, div_r;
  assign div_signed = (op == OP_DIV);
  assign a_mag  = (div_signed && E_MDUA[31]) ? (32'd0 - E_MDUA) : E_MDUA;
  assign b_mag  = (div_signed && E_MDUB[31]) ? (32'd0 - E_MDUB) : E_MDUB;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq     = a_mag / b_safe;
  assign ur     = a_mag % b_safe;
  assign q_neg  = div_signed && (E_MDUA[31] ^ E_MDUB[31]);
  assign r_neg  = div_signed && E_MDUA[31];
  assign div_q  = q_neg ? (32'd0 - uq) : uq;
  assign div_r  = r_neg ? (32'd0 - ur) : ur;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_n     = hi;
    lo_n     = lo;
    res_hi_n = res_hi;
    res_lo_n = res_lo;
    res_wr_n = res_wr;
    unique case (state)
      IDLE: begin
        if (E_Start) begin
          case (op)
            OP_MULT: begin
              {res_hi_n, res_lo_n} = prod_s;
              res_wr_n = 1'b1;
              cnt_n    = MULT_CYCLES;
              state_n  = RUN;
            end
            OP_MULTU: begin
              {res_hi_n, res_lo_n} = prod_u;
              res_wr_n = 1'b1;
              cnt_n    = MULT_CYCLES;
              state_n  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_lo_n = div_q;
              res_hi_n = div_r;
              res_wr_n = (E_MDUB != 32'd0);
              cnt_n    = DIV_CYCLES;
              state_n  = RUN;
            end
            OP_MTHI: hi_n = E_MDUA;
            OP_MTLO: lo_n = E_MDUA;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - 32'd1;
        if (cnt == 32'd1) begin
          state_n = IDLE;
          if (res_wr) begin
            hi_n = res_hi;
            lo_n = res_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi     <= hi_n;
      lo     <= lo_n;
      res_hi <= res_hi_n;
      res_lo <= res_lo_n;
      res_wr <= res_wr_n;
    end
  end

  assign E_Busy = (state == RUN);
  assign E_HI   = hi;
  assign E_LO   = lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, next to the combinational ALU.
- Consumes the same forwarded E-stage operands.
- Holds the architectural HI/LO registers for mult, multu, div, divu, mthi and mtlo.
- Reports a busy flag so the hazard unit can stall D-stage MDU instructions and mfhi/mflo until the result has landed.

Parameters:
- MULT_CYCLES, 5: cycles E_Busy stays high for mult/multu (≥1).
- DIV_CYCLES, 10: cycles E_Busy stays high for div/divu (≥1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- E_MDUA  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- E_MDUB  input  32  operand rt (divisor / multiplier)
- E_MDUOp  input  4  operation code, defined in Constants.v: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other codes are treated as none
- E_Start  input  1  one-cycle strobe; the instruction in E is an MDU op
- E_Busy  output  1  a registered multi-cycle operation is in flight
- E_HI  output  32  architectural HI register
- E_LO  output  32  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - E_HI=0, E_LO=0, E_Busy=0, counter=0, state=IDLE.
  - An in-flight operation is aborted and produces no HI/LO write.
- States are IDLE and RUN.
- In IDLE, on a clk edge with E_Start=1:
  - mult/multu/div/divu:
    - Compute the result from the operands sampled at this edge into internal resHI/resLO.
    - Load the counter with MULT_CYCLES or DIV_CYCLES.
    - Set E_Busy=1 and go to RUN.
  - mthi: E_HI <= E_MDUA at this edge. E_Busy stays 0, state stays IDLE.
  - mtlo: E_LO <= E_MDUA at this edge. E_Busy stays 0, state stays IDLE.
  - none/invalid: no state change.
- In RUN, on each edge the counter decrements. On the edge where the counter goes 1→0:
  - E_HI <= resHI and E_LO <= resLO.
  - E_Busy <= 0, return to IDLE.
  - Net effect: E_Busy is high for exactly N cycles, and the new HI/LO are visible in the first cycle E_Busy is low.
- E_Start while in RUN (any op, including mthi/mtlo) is ignored. The hazard unit must stall on (E_Start | E_Busy); the bench flags this case as a protocol violation but the DUT must not corrupt state.
- Operands are latched at start. Changes on E_MDUA/E_MDUB during RUN have no effect.
- E_HI/E_LO hold their old values during RUN.
- Arithmetic:
  - mult: signed 32x32→64; HI = bits[63:32], LO = bits[31:0].
  - multu: unsigned 32x32→64; same split.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - div overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
  - divu: unsigned quotient and remainder.
- Divide by zero (E_MDUB=0, div or divu): E_Busy runs the full DIV_CYCLES, and HI/LO are left unchanged at completion.
- Back-to-back ops: a new E_Start is accepted in the first cycle after E_Busy falls.
- E_Busy is registered and never combinational from E_Start.

Test Plan:
- mult A=0xFFFFFFFF, B=0x00000002 → E_Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → E_Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 → E_HI/E_LO update on the respective edges; E_Busy stays 0 throughout.
- HI=0xAAAA0000, LO=0x0000BBBB, then div A=5, B=0 → E_Busy high 10 cycles; HI/LO unchanged afterwards.
- During a mult (cycle 2 of 5), pulse E_Start with mtlo A=0xDEADBEEF and change E_MDUA/E_MDUB → ignored; the final HI/LO reflect the original operands only.
- Assert reset=0 mid-div (cycle 4 of 10) → E_Busy, E_HI and E_LO go to 0 immediately (asynchronous); after release, mult A=3, B=4 completes with HI=0, LO=12.
